// File: rtl/bfloat_pkg.sv
// bfloat16 divider shared types and widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bfloat_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 7;
  localparam int BIAS   = 127;
  localparam int WORD_W = 1 + EXP_W + MAN_W;
  // Quotient carries the integer bit, MAN_W fraction bits, guard and one sticky bit.
  localparam int QUO_W  = MAN_W + 3;
  // The remainder must hold mb and one extra bit for the left shift.
  localparam int REM_W  = MAN_W + 2;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    NORM,
    DONE
  } div_state_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } bf16_t;

  typedef struct packed {
    logic div_by_zero;
    logic overflow;
    logic underflow;
  } bf_flags_t;

endpackage

// File: rtl/bfloat_mant_div_step.sv
// One restoring-division step: compare, conditionally subtract, shift left.
// Latency: combinational.
// Backpressure: none.
// Ports: r (current remainder), mb (divisor mantissa with hidden 1),
//        r_nxt (remainder for the next step), q_bit (quotient bit produced).
module bfloat_mant_div_step
  import bfloat_pkg::*;
(
  input  logic [REM_W-1:0] r,
  input  logic [MAN_W:0]   mb,
  output logic [REM_W-1:0] r_nxt,
  output logic             q_bit
);

  logic [REM_W-1:0] diff;

  always_comb begin
    q_bit = (r >= {1'b0, mb});
    diff  = q_bit ? (r - {1'b0, mb}) : r;
    // After the restore diff < mb, so its MSB is always clear and the shift is lossless.
    r_nxt = diff << 1;
  end

endmodule

// File: rtl/bfloat_div.sv
// Sequential bfloat16 divider q = a / b, one quotient bit per clock, truncating.
// Latency: 12 edges (accept edge included) for normal operands, 1 for zero operands.
// Backpressure: in_ready only in IDLE; result and flags are held in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with operands a, b;
//        out_valid/out_ready with result q and flags div_by_zero, overflow, underflow.
// Build option: define BFLOAT_DIV_RNE_EN for round-to-nearest-even instead of truncation.
module bfloat_div
  import bfloat_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] q,
  output logic              div_by_zero,
  output logic              overflow,
  output logic              underflow
);

  localparam logic signed [EXP_W+1:0] E_BIAS  = (EXP_W+2)'(BIAS);
  localparam logic signed [EXP_W+1:0] E_MAX   = (EXP_W+2)'((1 << EXP_W) - 1);
  localparam logic signed [EXP_W+1:0] E_ONE   = (EXP_W+2)'(1);
  localparam logic signed [EXP_W+1:0] E_ZERO  = '0;
  localparam logic [3:0]              LAST_IT = 4'(QUO_W - 1);

  div_state_t              state_q, state_d;
  logic                    sign_q, sign_d;
  logic [MAN_W:0]          mb_q, mb_d;
  logic [REM_W-1:0]        r_q, r_d;
  logic [QUO_W-1:0]        quo_q, quo_d;
  logic [3:0]              cnt_q, cnt_d;
  logic signed [EXP_W+1:0] e_q, e_d;
  bf16_t                   res_q, res_d;
  bf_flags_t               flags_q, flags_d;

  bf16_t                   a_bf, b_bf;
  logic [REM_W-1:0]        step_r;
  logic                    step_bit;

  logic [MAN_W-1:0]        man_pre, norm_man;
  logic signed [EXP_W+1:0] e_pre, norm_e;
  bf16_t                   norm_res;
  bf_flags_t               norm_flags;

`ifdef BFLOAT_DIV_RNE_EN
  logic                    guard, sticky;
  logic [MAN_W:0]          man_rnd;
`else
  // Q[0] only feeds rounding, which this build does not do.
  logic                    unused_lsb;
  assign unused_lsb = quo_q[0];
`endif

  assign a_bf = a;
  assign b_bf = b;

  bfloat_mant_div_step u_step (
    .r     (r_q),
    .mb    (mb_q),
    .r_nxt (step_r),
    .q_bit (step_bit)
  );

  // Normalise: the quotient of two [1,2) mantissas lies in (0.5,2).
  always_comb begin
    if (quo_q[QUO_W-1]) begin
      man_pre = quo_q[QUO_W-2:2];
      e_pre   = e_q;
    end else begin
      man_pre = quo_q[QUO_W-3:1];
      e_pre   = e_q - E_ONE;
    end
`ifdef BFLOAT_DIV_RNE_EN
    if (quo_q[QUO_W-1]) begin
      guard  = quo_q[1];
      sticky = quo_q[0] | (|r_q);
    end else begin
      guard  = quo_q[0];
      sticky = |r_q;
    end
    man_rnd = {1'b0, man_pre} + {{MAN_W{1'b0}}, guard & (man_pre[0] | sticky)};
    if (man_rnd[MAN_W]) begin
      norm_man = '0;
      norm_e   = e_pre + E_ONE;
    end else begin
      norm_man = man_rnd[MAN_W-1:0];
      norm_e   = e_pre;
    end
`else
    norm_man = man_pre;
    norm_e   = e_pre;
`endif
  end

  // Range check on the final exponent; zero results are always +0.
  always_comb begin
    norm_res   = '0;
    norm_flags = '0;
    if (norm_e >= E_MAX) begin
      norm_res.sign       = sign_q;
      norm_res.exp        = '1;
      norm_flags.overflow = 1'b1;
    end else if (norm_e <= E_ZERO) begin
      norm_flags.underflow = 1'b1;
    end else begin
      norm_res.sign = sign_q;
      norm_res.exp  = norm_e[EXP_W-1:0];
      norm_res.man  = norm_man;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    mb_d    = mb_q;
    r_d     = r_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = a_bf.sign ^ b_bf.sign;
          mb_d    = {1'b1, b_bf.man};
          r_d     = {1'b0, 1'b1, a_bf.man};
          quo_d   = '0;
          cnt_d   = '0;
          e_d     = $signed({2'b00, a_bf.exp}) - $signed({2'b00, b_bf.exp}) + E_BIAS;
          flags_d = '0;
          // Divisor is checked first so 0/0 reports division by zero.
          if (b_bf.exp == '0) begin
            res_d               = '0;
            res_d.sign          = a_bf.sign ^ b_bf.sign;
            res_d.exp           = '1;
            flags_d.div_by_zero = 1'b1;
            state_d             = DONE;
          end else if (a_bf.exp == '0) begin
            res_d   = '0;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
      end
      DIV: begin
        r_d   = step_r;
        quo_d = {quo_q[QUO_W-2:0], step_bit};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_IT) begin
          state_d = NORM;
        end
      end
      NORM: begin
        e_d     = norm_e;
        res_d   = norm_res;
        flags_d = norm_flags;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mb_q    <= '0;
      r_q     <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      e_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      mb_q    <= mb_d;
      r_q     <= r_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign q           = res_q;
  assign div_by_zero = flags_q.div_by_zero;
  assign overflow    = flags_q.overflow;
  assign underflow   = flags_q.underflow;

endmodule

// File: tb/tb_bfloat_div.sv
// Scoreboard bench for bfloat_div: directed vectors push expected results,
// a negedge monitor compares on each output handshake, plus latency,
// hold-stability and reset-abort checks.
module tb_bfloat_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] q;
  logic        div_by_zero, overflow, underflow;

  typedef struct {
    logic [15:0] q;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;

  logic [15:0] snap_q;
  logic [2:0]  snap_f;
  bit          seen = 0;
  bit          post_hs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bfloat_div dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .q           (q),
    .div_by_zero (div_by_zero),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      seen    = 0;
      post_hs = 0;
    end else begin
      if (post_hs) begin
        chk("in_ready_after_handshake", {31'b0, in_ready}, 32'd1);
        post_hs = 0;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_out_valid: got q=0x%0h expected no output", q);
        end else begin
          chk("in_ready_low_in_done", {31'b0, in_ready}, 32'd0);
          if (!seen) begin
            seen   = 1;
            snap_q = q;
            snap_f = {div_by_zero, overflow, underflow};
            if (acc_q.size() != 0)
              chk("latency", cyc - acc_q[0] + 1, exp_q[0].lat);
          end else begin
            chk("hold_q_stable", {16'b0, q}, {16'b0, snap_q});
            chk("hold_flags_stable", {29'b0, div_by_zero, overflow, underflow}, {29'b0, snap_f});
          end
          if (out_ready) begin
            chk("result_q", {16'b0, q}, {16'b0, exp_q[0].q});
            chk("result_flags", {29'b0, div_by_zero, overflow, underflow}, {29'b0, exp_q[0].flags});
            void'(exp_q.pop_front());
            if (acc_q.size() != 0) void'(acc_q.pop_front());
            seen    = 0;
            post_hs = 1;
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] eq,
                      input logic [2:0] ef, input int lat, input bit score);
    int budget;
    exp_t e;
    budget   = 0;
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    while (!in_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    if (score) begin
      e.q = eq; e.flags = ef; e.lat = lat;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    if (score) acc_q.push_back(cyc);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    logic [15:0] third;
`ifdef BFLOAT_DIV_RNE_EN
    third = 16'h3EAB;
`else
    third = 16'h3EAA;
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_q", {16'b0, q}, 32'd0);
    chk("reset_flags", {29'b0, div_by_zero, overflow, underflow}, 32'd0);

    // flags = {div_by_zero, overflow, underflow}
    send(16'h40C0, 16'h4000, 16'h4040, 3'b000, 12, 1);  // 6/2
    send(16'h3F80, 16'h4040, third,    3'b000, 12, 1);  // 1/3
    send(16'hBF80, 16'h0000, 16'hFF80, 3'b100, 1,  1);  // -1/0
    send(16'h0000, 16'h40A0, 16'h0000, 3'b000, 1,  1);  // 0/5
    send(16'h7F00, 16'h0080, 16'h7F80, 3'b010, 12, 1);  // overflow
    send(16'h0080, 16'h7F00, 16'h0000, 3'b001, 12, 1);  // underflow
    send(16'hC0C0, 16'h4000, 16'hC040, 3'b000, 12, 1);  // -6/2
    send(16'h4040, 16'h4000, 16'h3FC0, 3'b000, 12, 1);  // 3/2
    send(16'h7F80, 16'h3F80, 16'h7F80, 3'b010, 12, 1);  // e == 255 boundary
    send(16'h0100, 16'h4000, 16'h0080, 3'b000, 12, 1);  // e == 1 boundary
    send(16'h0080, 16'h3FC0, 16'h0000, 3'b001, 12, 1);  // normalise drops e to 0
    send(16'h0000, 16'h0000, 16'h7F80, 3'b100, 1,  1);  // 0/0: divisor wins
    send(16'h8000, 16'h40A0, 16'h0000, 3'b000, 1,  1);  // -0/5 gives +0
    drain();

    // Output backpressure: hold out_ready low for 5 cycles after out_valid.
    out_ready = 1'b0;
    send(16'h40C0, 16'h4000, 16'h4040, 3'b000, 12, 1);
    begin
      int budget;
      budget = 0;
      while (!out_valid && budget < 50) begin
        @(posedge clk); #1;
        budget++;
      end
      if (!out_valid) begin
        n_checks++;
        n_err++;
        $display("FAIL hold_wait_valid: got out_valid=0 expected 1 within 50 cycles");
      end
    end
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    drain();

    // Reset during the division abandons it without producing output.
    send(16'h3F80, 16'h4040, 16'h0000, 3'b000, 0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    send(16'h3F80, 16'h3F80, 16'h3F80, 3'b000, 12, 1);  // 1/1 right after abort
    drain();
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bfloat_div.md
Name: bfloat_div

Overview:
- Sequential bfloat16 divider; the inverse operation of the existing bfloat16 multiplier, for the same MAC datapath.
- Computes q = a / b with a restoring mantissa division, one quotient bit per clock.
- Uses the same number handling as the multiplier: hidden-1 normals only, and truncation by default.
- Uses a valid/ready handshake on both its input and its output.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 7, stored mantissa width; the word width is 1+EXP_W+MAN_W.
- BIAS, 127, exponent bias; must equal 2^(EXP_W-1)-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands are valid.
- in_ready  out  1  divider is idle and can accept operands.
- a  in  16  dividend, bfloat16.
- b  in  16  divisor, bfloat16.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- q  out  16  quotient, bfloat16.
- div_by_zero  out  1  flag qualified by out_valid.
- overflow  out  1  flag qualified by out_valid.
- underflow  out  1  flag qualified by out_valid.

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, out_valid=0, q=0, all flags=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-operation abandons the operation and produces no output.
- FSM states: IDLE, DIV, NORM, DONE. in_ready = (state==IDLE).
- IDLE:
  - An accept (in_valid & in_ready) registers the sign sa^sb and the mantissas ma={1,a[6:0]}, mb={1,b[6:0]}.
  - It also registers the exponent difference e = ea - eb + BIAS, held signed in EXP_W+2 bits.
  - Special cases skip the division and go straight to DONE; b is checked first:
    - b exponent field == 0 (b treated as zero): q = {sign, all-ones exponent, 0 mantissa}, div_by_zero=1.
    - Otherwise, a exponent field == 0: q = 0x0000, no flags.
  - Every other input goes to DIV with remainder R=ma and iteration counter=0.
  - Exponent-field-all-ones inputs are treated as ordinary values, as in the multiplier.
- DIV: MAN_W+3 (=10) iterations, one per clock.
  - Each iteration: bit = (R >= mb); if bit, R = R - mb; then R = R << 1; shift bit into Q.
  - Q[9] is weight 2^0. R is 9 bits wide.
  - On the last iteration, go to NORM.
- NORM, one cycle:
  - If Q[9]=1: mantissa = Q[8:2], guard = Q[1].
  - Else: mantissa = Q[7:1], guard = Q[0], and e = e - 1.
  - sticky = OR of the lower Q bits beyond guard, OR (R != 0).
  - Range check:
    - e >= 2^EXP_W - 1: q = {sign, 0xFF, 0}, overflow=1.
    - e <= 0: q = 0x0000, underflow=1.
    - Otherwise q = {sign, e[7:0], mantissa}.
  - Go to DONE.
- DONE:
  - out_valid=1; q and flags are held stable until out_ready.
  - On the handshake (out_valid & out_ready): go to IDLE, out_valid=0.
  - A new accept is possible in the next cycle; there is no accept during DONE.
- Latency from the accept edge to out_valid high: 12 edges for normal operands, 1 edge for special cases. Throughput is one result per 13 cycles minimum.
- Zero results are always +0. Flags are mutually exclusive.

Optional Feature:
- Macro: BFLOAT_DIV_RNE_EN.
- Defined: round-to-nearest-even in NORM.
  - Increment the mantissa when guard & (mantissa[0] | sticky).
  - A mantissa carry-out sets mantissa=0 and e = e + 1.
  - The range check runs after rounding.
- Undefined: truncate; guard and sticky are ignored and need not be built.

Decomposition:
- Package bfloat_pkg holds:
  - localparams EXP_W, MAN_W, BIAS.
  - The div_state_t enum {IDLE, DIV, NORM, DONE}.
  - A bf16_t packed struct {sign, exp, man}.
  - A bf_flags_t struct {div_by_zero, overflow, underflow}.
- One sub-module, bfloat_mant_div_step: a combinational restoring step.
  - Inputs: R, mb.
  - Outputs: next R and the quotient bit.
  - Instantiated once in bfloat_div.

Test Plan:
- a=0x40C0 (6.0), b=0x4000 (2.0), out_ready=1 -> q=0x4040 (3.0), no flags, out_valid exactly 12 edges after accept.
- a=0x3F80 (1.0), b=0x4040 (3.0) -> q=0x3EAA without BFLOAT_DIV_RNE_EN; q=0x3EAB with BFLOAT_DIV_RNE_EN.
- a=0xBF80 (-1.0), b=0x0000 -> q=0xFF80, div_by_zero=1 one edge after accept; a=0x0000, b=0x40A0 -> q=0x0000, no flags.
- a=0x7F00, b=0x0080 -> q=0x7F80, overflow=1; a=0x0080, b=0x7F00 -> q=0x0000, underflow=1.
- Hold out_ready=0 for 5 cycles after out_valid, then pulse it -> q and flags stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- Assert rst during DIV (iteration 4) -> out_valid never rises, in_ready=1 the next cycle; a back-to-back accept then completes correctly (1.0/1.0 -> 0x3F80).
